// File: rtl/si_arith_pkg.sv
// Shared arithmetic definitions for the fixed-point neuron datapath:
// divider FSM states and helpers for the N-bit saturation bit patterns.
package si_arith_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } divState_t;

    // Largest positive N-bit two's-complement value, 2^(N-1)-1.
    function automatic logic [31:0] MAX_POS(input int n);
        return (32'd1 << (n - 1)) - 32'd1;
    endfunction

    // Bit pattern of the most negative N-bit value, -2^(N-1).
    function automatic logic [31:0] MIN_NEG(input int n);
        return 32'd1 << (n - 1);
    endfunction

endpackage

// File: rtl/si_div_seq_if.sv
// Start/done handshake, operand and result bundle between a requester and the sequential divider.
interface si_div_seq_if #(
    parameter int N = 8
);

    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         busy;
    logic         done;
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         divZero;
    logic         ovf;

    modport master (
        output start, a, b,
        input  busy, done, q, r, divZero, ovf
    );

    modport slave (
        input  start, a, b,
        output busy, done, q, r, divZero, ovf
    );

endinterface

// File: rtl/si_div_step.sv
// One restoring shift-subtract step on unsigned magnitudes: {rem, quo, |B|} -> {rem', quo'}.
module si_div_step #(
    parameter int N = 8
) (
    input  logic [N:0]   rem_i,
    input  logic [N-1:0] quo_i,
    input  logic [N-1:0] div_i,
    output logic [N:0]   rem_o,
    output logic [N-1:0] quo_o
);

    logic [N:0] shifted;
    logic       fits;

    // rem stays below |B| <= 2^N, so its top bit is always clear; OR-ing it in keeps the
    // comparison correct for the full shifted value without widening the datapath.
    always_comb begin
        shifted = {rem_i[N-1:0], quo_i[N-1]};
        fits    = rem_i[N] || (shifted >= {1'b0, div_i});
        rem_o   = fits ? (shifted - {1'b0, div_i}) : shifted;
        quo_o   = {quo_i[N-2:0], fits};
    end

endmodule

// File: rtl/si_div_seq.sv
// Sequential signed divider: fixed N+1 cycle latency, sign-corrected quotient and remainder,
// saturating on divide-by-zero and on the single overflowing case -2^(N-1) / -1.
module si_div_seq
    import si_arith_pkg::*;
#(
    parameter int N = 8
) (
    input logic          clk,
    input logic          rst_n,
    si_div_seq_if.slave  bus
);

    localparam int           CntW   = $clog2(N);
    localparam logic [N-1:0] MaxPos = N'(MAX_POS(N));
    localparam logic [N-1:0] MinNeg = N'(MIN_NEG(N));

    divState_t     state_q;
    logic [CntW-1:0] cnt_q;
    logic [N:0]    rem_q;
    logic [N-1:0]  quo_q;
    logic [N-1:0]  absB_q;
    logic [N-1:0]  a_q;
    logic          sgnA_q;
    logic          sgnB_q;
    logic          pendZero_q;
    logic          pendOvf_q;

    logic          busy_q;
    logic          done_q;
    logic [N-1:0]  q_q;
    logic [N-1:0]  r_q;
    logic          divZero_q;
    logic          ovf_q;

    logic [N:0]    rem_d;
    logic [N-1:0]  quo_d;

    function automatic logic [N-1:0] magnitude(input logic [N-1:0] v);
        return v[N-1] ? (~v + 1'b1) : v;
    endfunction

    si_div_step #(.N(N)) u_step (
        .rem_i (rem_q),
        .quo_i (quo_q),
        .div_i (absB_q),
        .rem_o (rem_d),
        .quo_o (quo_d)
    );

    // Zero and overflow are decided at capture time; the step loop always runs its full
    // length so latency never depends on the operands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            absB_q     <= '0;
            a_q        <= '0;
            sgnA_q     <= 1'b0;
            sgnB_q     <= 1'b0;
            pendZero_q <= 1'b0;
            pendOvf_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            q_q        <= '0;
            r_q        <= '0;
            divZero_q  <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        sgnA_q     <= bus.a[N-1];
                        sgnB_q     <= bus.b[N-1];
                        quo_q      <= magnitude(bus.a);
                        absB_q     <= magnitude(bus.b);
                        a_q        <= bus.a;
                        pendZero_q <= (bus.b == '0);
                        pendOvf_q  <= (bus.a == MinNeg) && (bus.b == '1);
                        rem_q      <= '0;
                        cnt_q      <= CntW'(N - 1);
                        busy_q     <= 1'b1;
                        state_q    <= CALC;
                    end
                end
                CALC: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == '0) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    if (pendZero_q) begin
                        q_q <= sgnA_q ? (~MaxPos + 1'b1) : MaxPos;
                        r_q <= a_q;
                    end else if (pendOvf_q) begin
                        q_q <= MaxPos;
                        r_q <= '0;
                    end else begin
                        q_q <= (sgnA_q ^ sgnB_q) ? (~quo_q + 1'b1) : quo_q;
                        r_q <= sgnA_q ? (~rem_q[N-1:0] + 1'b1) : rem_q[N-1:0];
                    end
                    divZero_q <= pendZero_q;
                    ovf_q     <= pendOvf_q && !pendZero_q;
                    busy_q    <= 1'b0;
                    done_q    <= 1'b1;
                    state_q   <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.q       = q_q;
    assign bus.r       = r_q;
    assign bus.divZero = divZero_q;
    assign bus.ovf     = ovf_q;

endmodule

// File: tb/tb_si_div_seq.sv
// Directed bench for si_div_seq (N=8): hand-computed quotients, remainders, flags and latency.
module tb_si_div_seq;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    int   lat;
    int   seen;

    si_div_seq_if #(.N(8)) bus ();

    si_div_seq #(.N(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%02h expected=0x%02h", tag, obs, exp);
        end
    endtask

    // Presents operands with START high across exactly one rising edge.
    task automatic applyStimulus(input logic [7:0] av, input logic [7:0] bv);
        bus.a     = av;
        bus.b     = bv;
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    task automatic waitDone(output int cycles);
        cycles = 0;
        do begin
            @(posedge clk);
            #1 cycles++;
        end while (!bus.done && cycles < 30);
    endtask

    task automatic checkResult(input string tag, input int expLat, input logic [7:0] q,
                               input logic [7:0] r, input logic dz, input logic ov);
        waitDone(lat);
        checkOutput({tag, "_lat"}, 8'(lat), 8'(expLat));
        checkOutput({tag, "_q"}, bus.q, q);
        checkOutput({tag, "_r"}, bus.r, r);
        checkOutput({tag, "_dz"}, {7'd0, bus.divZero}, {7'd0, dz});
        checkOutput({tag, "_ovf"}, {7'd0, bus.ovf}, {7'd0, ov});
    endtask

    task automatic countDone(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1 if (bus.done) n++;
        end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        rst_n     = 1'b1;
        #1 rst_n  = 1'b0;
        #2;
        checkOutput("rst_busy", {7'd0, bus.busy}, 8'd0);
        checkOutput("rst_done", {7'd0, bus.done}, 8'd0);
        checkOutput("rst_q", bus.q, 8'd0);
        checkOutput("rst_r", bus.r, 8'd0);
        checkOutput("rst_dz", {7'd0, bus.divZero}, 8'd0);
        checkOutput("rst_ovf", {7'd0, bus.ovf}, 8'd0);
        #9 rst_n = 1'b1;

        applyStimulus(8'd100, 8'd7);
        checkOutput("busy_after_start", {7'd0, bus.busy}, 8'd1);
        checkResult("p100_p7", 9, 8'h0E, 8'h02, 1'b0, 1'b0);
        checkOutput("busy_in_done", {7'd0, bus.busy}, 8'd0);
        @(posedge clk);
        #1 checkOutput("done_one_pulse", {7'd0, bus.done}, 8'd0);
        checkOutput("q_hold", bus.q, 8'h0E);

        applyStimulus(8'h9C, 8'd7);
        checkResult("m100_p7", 9, 8'hF2, 8'hFE, 1'b0, 1'b0);
        applyStimulus(8'd100, 8'hF9);
        checkResult("p100_m7", 9, 8'hF2, 8'h02, 1'b0, 1'b0);
        applyStimulus(8'h9C, 8'hF9);
        checkResult("m100_m7", 9, 8'h0E, 8'hFE, 1'b0, 1'b0);
        applyStimulus(8'h80, 8'h01);
        checkResult("m128_p1", 9, 8'h80, 8'h00, 1'b0, 1'b0);
        applyStimulus(8'h80, 8'hFF);
        checkResult("m128_m1", 9, 8'h7F, 8'h00, 1'b0, 1'b1);
        applyStimulus(8'd5, 8'd0);
        checkResult("p5_zero", 9, 8'h7F, 8'h05, 1'b1, 1'b0);
        applyStimulus(8'hFB, 8'd0);
        checkResult("m5_zero", 9, 8'h81, 8'hFB, 1'b1, 1'b0);

        // START pulsed mid-CALC with other operands must not disturb the running division.
        @(posedge clk);
        #1;
        applyStimulus(8'd100, 8'd7);
        repeat (3) @(posedge clk);
        #1;
        applyStimulus(8'd50, 8'd5);
        checkResult("ignore_start", 5, 8'h0E, 8'h02, 1'b0, 1'b0);

        // We now sit in the DONE cycle: a START here is accepted immediately.
        applyStimulus(8'd127, 8'hFD);
        checkResult("back_to_back", 9, 8'hD6, 8'h01, 1'b0, 1'b0);

        applyStimulus(8'd100, 8'd7);
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("abort_busy", {7'd0, bus.busy}, 8'd0);
        checkOutput("abort_done", {7'd0, bus.done}, 8'd0);
        checkOutput("abort_q", bus.q, 8'd0);
        checkOutput("abort_r", bus.r, 8'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        countDone(12, seen);
        checkOutput("abort_no_done", 8'(seen), 8'd0);
        checkOutput("abort_stays_idle", {7'd0, bus.busy}, 8'd0);

        @(negedge clk);
        applyStimulus(8'd9, 8'd3);
        checkResult("p9_p3", 9, 8'h03, 8'h00, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
